// File: rtl/io_break_hub_pkg.sv
// rtl/io_break_hub_pkg.sv - shared types and helpers for the I/O break hub
package io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } brk_state_e;

    localparam int NCH_MAX = 8;

    function automatic int iw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First requester at or after ptr, wrapping within n channels; ptr is returned when none request.
    function automatic logic [2:0] rr_pick(input logic [NCH_MAX-1:0] req,
                                           input logic [2:0] ptr,
                                           input int n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NCH_MAX; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/io_break_hub_if.sv
// rtl/io_break_hub_if.sv - break handshake and DMA bus towards state_machine/ma
interface io_break_hub_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          data_break;
    logic          break_in_prog;
    logic [AW-1:0] dma_addr;
    logic          to_mem;
    logic [DW-1:0] dma_dout;
    logic [DW-1:0] dma_din;

    modport master (
        output data_break, dma_addr, to_mem, dma_dout,
        input  break_in_prog, dma_din
    );

    modport slave (
        input  data_break, dma_addr, to_mem, dma_dout,
        output break_in_prog, dma_din
    );
endinterface

// File: rtl/io_break_hub_irq_agg.sv
// rtl/io_break_hub_irq_agg.sv - per-channel interrupt latch, mask and aggregation
module irq_agg
    import io_pkg::*;
#(
    parameter int             NCH      = 4,
    parameter logic [NCH-1:0] IRQ_EDGE = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic [NCH-1:0] irq_in,
    input  logic [NCH-1:0] irq_ack,
    input  logic           mask_we,
    input  logic [NCH-1:0] mask_din,
    output logic [NCH-1:0] irq_pend,
    output logic           irq
);

    logic [NCH-1:0] irq_prev_q, irq_prev_d;
    logic [NCH-1:0] edge_q, edge_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] pend_raw;

    always_comb begin
        irq_prev_d = irq_in;
        // A new rising edge overrides an acknowledge in the same cycle.
        edge_d = ((edge_q & ~irq_ack) | (irq_in & ~irq_prev_q)) & IRQ_EDGE;
        if (clear) edge_d = '0;
        pend_raw = (IRQ_EDGE & edge_q) | (~IRQ_EDGE & irq_in);
        mask_d   = clear ? '1 : (mask_we ? mask_din : mask_q);
        pend_d   = pend_raw & mask_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            edge_q     <= '0;
            mask_q     <= '1;
            pend_q     <= '0;
        end else begin
            irq_prev_q <= irq_prev_d;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
        end
    end

    assign irq_pend = pend_q;
    assign irq      = |pend_q;

endmodule

// File: rtl/io_break_hub.sv
// rtl/io_break_hub.sv - round-robin data-break arbiter/sequencer plus interrupt hub
module io_break_hub
    import io_pkg::*;
#(
    parameter int             NCH      = 4,
    parameter int             AW       = 15,
    parameter int             DW       = 12,
    parameter logic [NCH-1:0] IRQ_EDGE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [NCH-1:0]    brk_req,
    input  logic [NCH*AW-1:0] brk_addr,
    input  logic [NCH-1:0]    brk_wr,
    input  logic [NCH*DW-1:0] brk_wdata,
    output logic [NCH-1:0]    brk_gnt,
    output logic [DW-1:0]     brk_rdata,
    io_break_hub_if.master    sm,
    input  logic [NCH-1:0]    irq_in,
    input  logic [NCH-1:0]    irq_ack,
    input  logic              mask_we,
    input  logic [NCH-1:0]    mask_din,
    output logic              irq,
    output logic [NCH-1:0]    irq_pend,
    output logic              busy
);

    localparam int IW = iw_of(NCH);

    brk_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] win_q, win_d;
    logic [AW-1:0] dma_addr_q, dma_addr_d;
    logic          to_mem_q, to_mem_d;
    logic [DW-1:0] dma_dout_q, dma_dout_d;
    logic [DW-1:0] brk_rdata_q, brk_rdata_d;
    logic [NCH-1:0] brk_gnt_q, brk_gnt_d;
    logic          data_break_q, data_break_d;
    logic          busy_q, busy_d;

    logic [NCH_MAX-1:0] req_ext;
    logic [2:0]         pick;
    logic [IW-1:0]      win_pick;

    assign req_ext  = NCH_MAX'(brk_req);
    assign pick     = rr_pick(req_ext, 3'(rr_ptr_q), NCH);
    assign win_pick = IW'(pick);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        dma_addr_d  = dma_addr_q;
        to_mem_d    = to_mem_q;
        dma_dout_d  = dma_dout_q;
        brk_rdata_d = brk_rdata_q;
        brk_gnt_d   = '0;
        case (state_q)
            IDLE: if (|brk_req) begin
                state_d    = REQ;
                win_d      = win_pick;
                dma_addr_d = brk_addr[int'(win_pick)*AW +: AW];
                to_mem_d   = brk_wr[win_pick];
                dma_dout_d = brk_wdata[int'(win_pick)*DW +: DW];
            end
            REQ: begin
                // Abort is only safe before the state machine has taken the break.
                if (clear) begin
                    state_d    = IDLE;
                    dma_addr_d = '0;
                    to_mem_d   = 1'b0;
                    dma_dout_d = '0;
                end else if (sm.break_in_prog) begin
                    state_d = XFER;
                end
            end
            XFER: if (!sm.break_in_prog) begin
                state_d          = DONE;
                brk_rdata_d      = sm.dma_din;
                brk_gnt_d[win_q] = 1'b1;
            end
            DONE: begin
                state_d    = IDLE;
                rr_ptr_d   = (win_q == IW'(NCH - 1)) ? '0 : win_q + 1'b1;
                dma_addr_d = '0;
                to_mem_d   = 1'b0;
                dma_dout_d = '0;
            end
            default: state_d = IDLE;
        endcase
        data_break_d = (state_d == REQ) || (state_d == XFER);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            dma_addr_q   <= '0;
            to_mem_q     <= 1'b0;
            dma_dout_q   <= '0;
            brk_rdata_q  <= '0;
            brk_gnt_q    <= '0;
            data_break_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            dma_addr_q   <= dma_addr_d;
            to_mem_q     <= to_mem_d;
            dma_dout_q   <= dma_dout_d;
            brk_rdata_q  <= brk_rdata_d;
            brk_gnt_q    <= brk_gnt_d;
            data_break_q <= data_break_d;
            busy_q       <= busy_d;
        end
    end

    assign sm.data_break = data_break_q;
    assign sm.dma_addr   = dma_addr_q;
    assign sm.to_mem     = to_mem_q;
    assign sm.dma_dout   = dma_dout_q;
    assign brk_gnt       = brk_gnt_q;
    assign brk_rdata     = brk_rdata_q;
    assign busy          = busy_q;

    irq_agg #(
        .NCH      (NCH),
        .IRQ_EDGE (IRQ_EDGE)
    ) u_irq_agg (
        .clk      (clk),
        .rst_n    (reset),
        .clear    (clear),
        .irq_in   (irq_in),
        .irq_ack  (irq_ack),
        .mask_we  (mask_we),
        .mask_din (mask_din),
        .irq_pend (irq_pend),
        .irq      (irq)
    );

endmodule

// File: tb/tb_io_break_hub.sv
// tb/tb_io_break_hub.sv - directed self-checking bench for io_break_hub
module tb_io_break_hub;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [3:0]  brk_req;
    logic [59:0] brk_addr;
    logic [3:0]  brk_wr;
    logic [47:0] brk_wdata;
    logic [3:0]  brk_gnt;
    logic [11:0] brk_rdata;
    logic [3:0]  irq_in;
    logic [3:0]  irq_ack;
    logic        mask_we;
    logic [3:0]  mask_din;
    logic        irq;
    logic [3:0]  irq_pend;
    logic        busy;

    int checks = 0;
    int errors = 0;

    io_break_hub_if #(.AW(15), .DW(12)) sm_if ();

    io_break_hub #(
        .NCH      (4),
        .AW       (15),
        .DW       (12),
        .IRQ_EDGE (4'b0010)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .brk_req   (brk_req),
        .brk_addr  (brk_addr),
        .brk_wr    (brk_wr),
        .brk_wdata (brk_wdata),
        .brk_gnt   (brk_gnt),
        .brk_rdata (brk_rdata),
        .sm        (sm_if.master),
        .irq_in    (irq_in),
        .irq_ack   (irq_ack),
        .mask_we   (mask_we),
        .mask_din  (mask_din),
        .irq       (irq),
        .irq_pend  (irq_pend),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input int nb, input logic [11:0] din,
                         output logic [3:0] gnt, output int idle);
        int guard;
        idle  = 0;
        guard = 0;
        while (!sm_if.data_break && guard < 20) begin
            if (!busy) idle++;
            tick();
            guard++;
        end
        chk("serve_data_break", 32'(sm_if.data_break), 32'd1);
        sm_if.dma_din       = din;
        sm_if.break_in_prog = 1'b1;
        repeat (nb) tick();
        sm_if.break_in_prog = 1'b0;
        tick();
        gnt = brk_gnt;
    endtask

    logic [3:0] g;
    int         idl;

    initial begin
        reset = 1'b0; clear = 1'b0; brk_req = '0; brk_wr = 4'b0100;
        irq_in = '0; irq_ack = '0; mask_we = 1'b0; mask_din = '0;
        sm_if.break_in_prog = 1'b0; sm_if.dma_din = '0;
        brk_addr  = {15'o00300, 15'o01234, 15'o00200, 15'o00100};
        brk_wdata = {12'o3333, 12'o7654, 12'o2222, 12'o1111};

        tick(); tick();
        chk("rst_data_break", 32'(sm_if.data_break), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(brk_gnt), 32'd0);
        chk("rst_dma_addr", 32'(sm_if.dma_addr), 32'd0);
        chk("rst_rdata", 32'(brk_rdata), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_pend", 32'(irq_pend), 32'd0);
        reset = 1'b1;
        tick();

        // Round-robin among ch0, ch1, ch3 starting from pointer 0
        brk_req = 4'b1011;
        serve(1, 12'o0, g, idl); chk("rr_gnt0", 32'(g), 32'h1); chk("rr_idle0", 32'(idl), 32'd1);
        serve(2, 12'o0, g, idl); chk("rr_gnt1", 32'(g), 32'h2); chk("rr_idle1", 32'(idl), 32'd1);
        serve(1, 12'o0, g, idl); chk("rr_gnt2", 32'(g), 32'h8); chk("rr_idle2", 32'(idl), 32'd1);
        serve(1, 12'o0, g, idl); chk("rr_gnt3", 32'(g), 32'h1); chk("rr_idle3", 32'(idl), 32'd1);
        brk_req = '0;
        tick();

        // Single write break on ch2
        brk_req = 4'b0100;
        chk("sb_idle_db", 32'(sm_if.data_break), 32'd0);
        tick();
        chk("sb_data_break", 32'(sm_if.data_break), 32'd1);
        chk("sb_dma_addr", 32'(sm_if.dma_addr), 32'o01234);
        chk("sb_to_mem", 32'(sm_if.to_mem), 32'd1);
        chk("sb_dma_dout", 32'(sm_if.dma_dout), 32'o7654);
        sm_if.break_in_prog = 1'b1;
        repeat (3) tick();
        chk("sb_no_gnt_yet", 32'(brk_gnt), 32'd0);
        chk("sb_db_held", 32'(sm_if.data_break), 32'd1);
        sm_if.break_in_prog = 1'b0;
        tick();
        chk("sb_gnt", 32'(brk_gnt), 32'h4);
        brk_req = '0;
        tick();
        chk("sb_busy_after", 32'(busy), 32'd0);
        chk("sb_addr_after", 32'(sm_if.dma_addr), 32'd0);

        // Read break on ch1
        brk_req = 4'b0010;
        serve(2, 12'o0017, g, idl);
        chk("rd_gnt", 32'(g), 32'h2);
        chk("rd_rdata", 32'(brk_rdata), 32'o0017);
        chk("rd_to_mem", 32'(sm_if.to_mem), 32'd0);
        brk_req = '0;
        tick();

        // Clear in REQ aborts without grant and keeps the pointer at 2
        brk_req = 4'b1001;
        tick();
        chk("clr_req_db", 32'(sm_if.data_break), 32'd1);
        chk("clr_req_addr", 32'(sm_if.dma_addr), 32'o00300);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_db_drop", 32'(sm_if.data_break), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_no_gnt", 32'(brk_gnt), 32'd0);
        serve(1, 12'o0, g, idl);
        chk("clr_ptr_kept", 32'(g), 32'h8);

        // Clear in XFER and DONE is ignored
        tick(); tick();
        chk("cx_req", 32'(sm_if.data_break), 32'd1);
        sm_if.break_in_prog = 1'b1;
        tick();
        clear = 1'b1;
        tick();
        chk("cx_db_held", 32'(sm_if.data_break), 32'd1);
        sm_if.break_in_prog = 1'b0;
        tick();
        chk("cx_gnt", 32'(brk_gnt), 32'h1);
        brk_req = '0;
        tick();
        clear = 1'b0;
        tick();

        // Edge channel 1: one-cycle pulse, held until ack
        irq_in = 4'b0010;
        tick();
        irq_in = 4'b0000;
        chk("edge_lag1", 32'(irq), 32'd0);
        tick();
        chk("edge_irq", 32'(irq), 32'd1);
        tick(); tick();
        chk("edge_held", 32'(irq_pend), 32'h2);
        irq_ack = 4'b0010;
        tick();
        irq_ack = 4'b0000;
        tick();
        chk("edge_acked", 32'(irq), 32'd0);

        // Level channel 0
        irq_in = 4'b0001;
        tick();
        chk("lvl_on", 32'(irq_pend), 32'h1);
        irq_in = 4'b0000;
        tick();
        chk("lvl_off", 32'(irq), 32'd0);

        // Mask suppresses ch0
        mask_we = 1'b1; mask_din = 4'b1110;
        tick();
        mask_we = 1'b0;
        irq_in = 4'b0001;
        tick(); tick();
        chk("mask_ch0", 32'(irq), 32'd0);
        irq_in = 4'b0000;

        // Edge and ack in the same cycle on a set latch: latch stays set
        irq_in = 4'b0010;
        tick();
        irq_in = 4'b0000;
        tick();
        irq_in = 4'b0010; irq_ack = 4'b0010;
        tick();
        irq_in = 4'b0000; irq_ack = 4'b0000;
        tick(); tick();
        chk("edge_ack_same", 32'(irq_pend), 32'h2);
        irq_ack = 4'b0010;
        tick();
        irq_ack = 4'b0000;
        tick();

        // Asynchronous reset during XFER
        brk_req = 4'b0100;
        tick();
        sm_if.break_in_prog = 1'b1;
        tick();
        chk("ar_in_xfer", 32'(sm_if.data_break), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_db", 32'(sm_if.data_break), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_addr", 32'(sm_if.dma_addr), 32'd0);
        chk("ar_to_mem", 32'(sm_if.to_mem), 32'd0);
        chk("ar_dout", 32'(sm_if.dma_dout), 32'd0);
        tick();
        reset = 1'b1;
        sm_if.break_in_prog = 1'b0;
        brk_req = 4'b1001;
        chk("ar_idle", 32'(busy), 32'd0);
        serve(1, 12'o0, g, idl);
        chk("ar_ptr_zero", 32'(g), 32'h1);
        brk_req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_break_hub.md
# io_break_hub

Parametrised I/O channel hub for the PDP-8/E core. It generalises the single-device data-break path and the fixed interrupt OR into NCH device channels. Data-break requests are arbitrated round-robin and sequenced against the state machine's `data_break`/`break_in_prog` handshake. Interrupt requests are aggregated with per-channel mask and per-channel level/edge mode. It sits between the peripherals (serial, RK8E, future devices) and the `state_machine`/`ma` blocks.

## Interface
- `NCH`, default 4: number of device channels, 1..8.
- `AW`, default 15: break address width, EMA plus 12-bit address.
- `DW`, default 12: data word width.
- `IRQ_EDGE`, default 0: NCH-bit mask; bit k=1 makes channel k edge-latched, 0 makes it level.
- `clk` in, 1: system clock, the 100 MHz domain.
- `reset` in, 1: asynchronous, active-low reset.
- `clear` in, 1: front-panel/CAF clear pulse.
- `brk_req` in, NCH: per-channel break request. Held high until that channel's grant.
- `brk_addr` in, NCH*AW: per-channel address. Channel k occupies bits [k*AW +: AW].
- `brk_wr` in, NCH: 1 = device-to-memory, 0 = memory-to-device.
- `brk_wdata` in, NCH*DW: per-channel write data.
- `brk_gnt` out, NCH: one-cycle completion pulse to the winning channel.
- `brk_rdata` out, DW: memory read data, valid in the `brk_gnt` cycle.
- `data_break` out, 1: break request to `state_machine`.
- `break_in_prog` in, 1: break cycle active, from `state_machine`.
- `dma_addr` out, AW: address to `ma`.
- `to_mem` out, 1: write direction to `ma`.
- `dma_dout` out, DW: write data to `ma`.
- `dma_din` in, DW: read data from `ma`.
- `irq_in` in, NCH: device interrupt lines.
- `irq_ack` in, NCH: one-cycle pulse that clears edge latch k.
- `mask_we` in, 1: loads `mask_din` into the mask register.
- `mask_din` in, NCH: new mask value.
- `irq` out, 1: aggregated interrupt request to `state_machine`/`mem_ext`.
- `irq_pend` out, NCH: registered masked pending vector, for the display mux.
- `busy` out, 1: FSM is not in IDLE.

## Operation
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE, when any `brk_req` is high:
  - Pick the winner: the first requesting channel at or after `rr_ptr`, wrapping modulo NCH.
  - Latch the winner index, its address, direction and write data.
  - Go to REQ.
- REQ: drive `data_break`=1. When `break_in_prog` is 1, go to XFER.
- XFER: keep `data_break`=1. When `break_in_prog` is 0, capture `dma_din` into `brk_rdata` and go to DONE.
- DONE:
  - Pulse `brk_gnt[winner]`.
  - Set `rr_ptr` to (winner+1) mod NCH.
  - Go to IDLE.
- Requests that arrive or drop while the FSM is not in IDLE are ignored until the next IDLE.
- `dma_addr`, `to_mem` and `dma_dout` are driven from the latched values in REQ/XFER/DONE. In IDLE they are 0.
- `clear` in REQ: return to IDLE with no grant, and keep `rr_ptr` unchanged.
- `clear` in XFER/DONE: ignored, so a break that has started always completes.
- Interrupt latch per channel:
  - Level channel: pend_raw[k] = `irq_in[k]`.
  - Edge channel: pend_raw[k] is set on a 0→1 edge of `irq_in[k]`, using a registered previous value.
  - An edge latch clears on `irq_ack[k]`; set wins if set and ack occur in the same cycle.
  - `clear` clears all edge latches.
- `irq_pend` = pend_raw & mask, registered. `irq` = |`irq_pend`.
- `mask_we` takes effect on the next clock.
- `clear` sets mask to all ones.

## Timing
- Reset values:
  - FSM IDLE, `rr_ptr`=0, mask all ones, edge latches 0.
  - All outputs 0: `brk_gnt`, `brk_rdata`, `data_break`, `dma_*`, `to_mem`, `irq`, `irq_pend`, `busy`.
- `data_break` rises 1 cycle after the IDLE cycle that sees a request.
- Minimum break latency: request, then 1 cycle to REQ, then `break_in_prog` response, then XFER, then 1 cycle to DONE. `brk_gnt` is asserted exactly 1 cycle after `break_in_prog` falls.
- Back-to-back breaks: IDLE lasts exactly 1 cycle between grants when requests are pending.
- `irq_in` to `irq`: 1 cycle for level channels, 2 cycles for edge channels (edge register, then pend register).
- Asynchronous reset asserted mid-break drops `data_break` immediately. The state machine must tolerate this; a test covers it.
- NCH=1 degenerates to a fixed grant, and `rr_ptr` stays at 0.

## Structure
- Shared package `io_pkg`:
  - FSM state encoding constants IDLE=0, REQ=1, XFER=2, DONE=3.
  - Function `rr_pick(req, ptr)` returning the winner index.
  - Localparam `IW` = clog2(NCH), minimum 1.
- Sub-module `irq_agg`: the interrupt latch, mask and aggregation, parametrised by NCH and IRQ_EDGE.
- The arbiter and FSM stay in the top module.

## Test plan
- Single break: ch2 requests with addr 15'o01234, `brk_wr`=1, data 12'o7654. Expect `data_break` next cycle. After `break_in_prog` pulses 3 cycles: `dma_addr`=01234, `to_mem`=1, `dma_dout`=7654; `brk_gnt`=4'b0100 one cycle after `break_in_prog` falls.
- Round-robin: ch0, ch1 and ch3 held requesting. Expect grant order 0,1,3,0, with exactly one idle cycle between grants.
- Read break: ch1 with `brk_wr`=0 and `dma_din`=12'o0017 during XFER. Expect `brk_rdata`=0017 in the grant cycle.
- Clear abort: `clear` in REQ drops `data_break` next cycle, gives no grant, and `rr_ptr` is unchanged. `clear` in XFER still completes the grant.
- Interrupts with IRQ_EDGE=4'b0010:
  - ch1 pulses 1 cycle: `irq` high 2 cycles later and held until `irq_ack[1]`.
  - ch0 level: `irq` follows `irq_in[0]` with 1-cycle lag.
  - With mask=4'b1110, ch0 is suppressed.
  - Simultaneous edge on ch1 and `irq_ack[1]`: the latch stays set.
- Reset mid-XFER: assert `reset` low. All outputs go to 0 asynchronously. After release, FSM is IDLE and `rr_ptr`=0.
